ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
Sequencer for the simple dual-port RAM IP (port A write, port B read). On a start pulse it writes a deterministic pattern across the whole RAM, reads it back through port B, compares each word against the expected value while compensating for the RAM read latency, and reports pass/fail, the error count and the first failing address. It sits between the top level (sys_clk/sys_rst_n domain) and the RAM instance. It is the only driver of both RAM ports.

Parameters:
ADDR_W, 5, RAM address width.
DATA_W, 8, RAM data width.
DEPTH, 32, number of words exercised; 2 <= DEPTH <= 2^ADDR_W.
RD_LAT, 1, RAM port-B read latency in clocks (1 or 2); rd_data for the address issued at edge t is sampled at edge t+RD_LAT.

Ports:
sys_clk  in  1  system clock, all logic rising-edge.
sys_rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; honoured only in IDLE.
ram_wr_en  out  1  port A write enable.
ram_wr_addr  out  ADDR_W  port A address.
ram_wr_data  out  DATA_W  port A data.
ram_rd_en  out  1  port B read enable.
ram_rd_addr  out  ADDR_W  port B address.
ram_rd_data  in  DATA_W  port B read data.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the run completes.
pass  out  1  1 when the last run had zero mismatches; held until the next accepted start.
err_cnt  out  ADDR_W+1  mismatch count of the current/last run.
first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset (async, sys_rst_n=0): state IDLE; all outputs 0, including pass. Reset mid-run aborts immediately; no done pulse is issued.
- All outputs are registered. Single address counter: 0..DEPTH-1.
- FSM states: IDLE, WRITE, WAIT, READ, DRAIN, DONE.
- IDLE: when start=1, clear err_cnt, first_err_addr, pass and the address counter, then go to WRITE. start is ignored in every other state, including DONE.
- WRITE: lasts DEPTH cycles. ram_wr_en=1, ram_wr_addr=counter, ram_wr_data=pattern(counter). After address DEPTH-1, go to WAIT.
- WAIT: one turnaround cycle. No enables asserted. Counter reset to 0.
- READ: lasts DEPTH cycles. ram_rd_en=1, ram_rd_addr=counter. An RD_LAT-deep shift pipe carries {valid, addr, expected}. After address DEPTH-1, go to DRAIN.
- DRAIN: lasts RD_LAT cycles, which flushes the pipe. Then go to DONE.
- Compare: whenever the pipe output is valid, compare ram_rd_data against expected. On mismatch, increment err_cnt (saturates at 2^(ADDR_W+1)-1). On the first mismatch of a run, capture the address in first_err_addr.
- DONE: lasts one cycle. done=1, pass=(err_cnt==0 including any mismatch on the final compare). Then go to IDLE.
- Latency: if start is sampled at edge 0, done is high in the cycle after edge 2*DEPTH+RD_LAT+1, i.e. edge 66 for DEPTH=32, RD_LAT=1. busy goes high after edge 0 and low after the edge that leaves DONE.
- Default pattern: pattern(a) = a zero-extended or truncated to DATA_W, XOR {DATA_W{1'b1}} when a is odd. This catches stuck bits and address aliasing.
- Writes and reads never overlap, so port collision is impossible by construction.

Optional Feature:
Macro: BIST_LFSR_PATTERN_EN.
- Defined: pattern is a DATA_W=8 Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded with 8'h01 at address 0 and stepped once per address. The write side and the read side each have their own LFSR, both reseeded at WRITE entry and READ entry respectively. Elaboration error if DATA_W != 8.
- Undefined: default address-based pattern; no LFSR logic is instantiated.

Test Plan:
- Ideal RAM model (RD_LAT=1, DEPTH=32); pulse start -> 32 writes with addr 0..31 and data 00,FE,02,FC...; done pulse after edge 66; pass=1, err_cnt=0, first_err_addr=0.
- RAM model flips bit 3 on the read of addr 5 and addr 20 -> err_cnt=2, first_err_addr=5, pass=0; a following clean run clears the flags and gives pass=1.
- RD_LAT=2 with matching model -> pass=1, done after edge 67; with a RD_LAT=2 RAM driven as if RD_LAT=1 -> err_cnt=32 (every compare misaligned, since the default pattern has no consecutive equal words).
- start pulsed during WRITE, READ and DONE -> ignored: exactly one done pulse, no counter restart.
- sys_rst_n low during READ at addr 10 -> all outputs 0 asynchronously, no done; a new start after release completes normally with pass=1.
- BIST_LFSR_PATTERN_EN defined -> ram_wr_data at addr 0 = 8'h01, the sequence matches the reference LFSR model, and a clean model gives pass=1.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write/read-back BIST sequencer for a simple dual-port RAM (port A write, port B read).
// Define BIST_LFSR_PATTERN_EN to use an 8-bit Galois LFSR data pattern instead of the address-based one.
module ram_bist_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   parameter int RD_LAT = 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              start,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);
   typedef enum logic [2:0] {IDLE, WRITE, WAIT, READ, DRAIN, DONE} state_t;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   state_t              state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic                drn_q;
   logic [RD_LAT-1:0]   pv_q;
   logic [ADDR_W-1:0]   pa_q [RD_LAT];
   logic [DATA_W-1:0]   pe_q [RD_LAT];
   logic [DATA_W-1:0]   exp_in, wr_first, wr_next;
   logic                mis;
   logic [ADDR_W:0]     err_cnt_d;

   assign ram_wr_addr = cnt_q;
   assign ram_rd_addr = cnt_q;

`ifdef BIST_LFSR_PATTERN_EN
   if (DATA_W != 8) begin : g_bad_width
      $error("BIST_LFSR_PATTERN_EN requires DATA_W == 8");
   end
   localparam logic [DATA_W-1:0] SEED = DATA_W'(1);
   logic [DATA_W-1:0] rd_lfsr_q;
   function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
      return {s[DATA_W-2:0], 1'b0} ^ (s[DATA_W-1] ? DATA_W'(8'h71) : '0);
   endfunction
   assign wr_first = SEED;
   assign wr_next  = lfsr_step(ram_wr_data);
   assign exp_in   = rd_lfsr_q;
   // read-side LFSR tracks the read address: reseeded as READ starts, stepped with every read
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rd_lfsr_q <= '0;
      else rd_lfsr_q <= state_q == WAIT ? SEED : state_q == READ ? lfsr_step(rd_lfsr_q) : rd_lfsr_q;
   end
`else
   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) ^ {DATA_W{a[0]}};
   endfunction
   assign wr_first = pat('0);
   assign wr_next  = pat(cnt_q + ADDR_W'(1));
   assign exp_in   = pat(cnt_q);
`endif

   assign mis       = pv_q[RD_LAT-1] && (ram_rd_data != pe_q[RD_LAT-1]);
   assign err_cnt_d = err_cnt + {{ADDR_W{1'b0}}, mis & ~&err_cnt};

   // compare pipe: carries {valid, addr, expected} alongside the RAM read latency
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pv_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pa_q[i] <= '0;
            pe_q[i] <= '0;
         end
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            pv_q[i] <= pv_q[i-1];
            pa_q[i] <= pa_q[i-1];
            pe_q[i] <= pe_q[i-1];
         end
         pv_q[0] <= ram_rd_en;
         pa_q[0] <= cnt_q;
         pe_q[0] <= exp_in;
      end
   end

   // sequencer FSM with registered outputs and error bookkeeping
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         drn_q          <= 1'b0;
         ram_wr_en      <= 1'b0;
         ram_wr_data    <= '0;
         ram_rd_en      <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
      end else begin
         done    <= 1'b0;
         err_cnt <= err_cnt_d;
         if (mis && err_cnt == '0) first_err_addr <= pa_q[RD_LAT-1];
         case (state_q)
            IDLE: if (start) begin
               state_q        <= WRITE;
               cnt_q          <= '0;
               ram_wr_en      <= 1'b1;
               ram_wr_data    <= wr_first;
               busy           <= 1'b1;
               pass           <= 1'b0;
               err_cnt        <= '0;
               first_err_addr <= '0;
            end
            WRITE: if (cnt_q == LAST) begin
               state_q   <= WAIT;
               ram_wr_en <= 1'b0;
               cnt_q     <= '0;
            end else begin
               cnt_q       <= cnt_q + ADDR_W'(1);
               ram_wr_data <= wr_next;
            end
            WAIT: begin
               state_q   <= READ;
               ram_rd_en <= 1'b1;
               cnt_q     <= '0;
            end
            READ: if (cnt_q == LAST) begin
               state_q   <= DRAIN;
               ram_rd_en <= 1'b0;
               drn_q     <= 1'b0;
            end else cnt_q <= cnt_q + ADDR_W'(1);
            DRAIN: if (drn_q == 1'(RD_LAT - 1)) begin
               state_q <= DONE;
               done    <= 1'b1;
               pass    <= err_cnt_d == '0;
            end else drn_q <= 1'b1;
            DONE: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed bench for ram_bist_ctrl with behavioural RAM models (latency 1 and 2).
module tb_ram_bist_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic flip = 1'b0, lat2 = 1'b0;
   logic wr_en1, rd_en1, busy1, done1, pass1, wr_en2, rd_en2, busy2, done2, pass2;
   logic [4:0] wr_addr1, rd_addr1, first1, wr_addr2, rd_addr2, first2;
   logic [7:0] wr_data1, rd_data1, wr_data2, rd_data2, r1a, r1b, r2a, r2b;
   logic [5:0] err1, err2;
   logic [7:0] mem1 [32];
   logic [7:0] mem2 [32];
   int checks = 0, failures = 0;
   int dedge, ndone;
   logic bafter;

   always #5 clk = ~clk;

   ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(1)) u_dut1 (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(start1),
      .ram_wr_en(wr_en1), .ram_wr_addr(wr_addr1), .ram_wr_data(wr_data1),
      .ram_rd_en(rd_en1), .ram_rd_addr(rd_addr1), .ram_rd_data(rd_data1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(first1));

   ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(2)) u_dut2 (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(start2),
      .ram_wr_en(wr_en2), .ram_wr_addr(wr_addr2), .ram_wr_data(wr_data2),
      .ram_rd_en(rd_en2), .ram_rd_addr(rd_addr2), .ram_rd_data(rd_data2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err_addr(first2));

   // RAM models: r1a is a latency-1 port, r1b/r2b are latency-2 ports
   always @(posedge clk) begin
      if (wr_en1) mem1[wr_addr1] <= wr_data1;
      if (rd_en1) r1a <= mem1[rd_addr1] ^ ((flip && (rd_addr1 == 5'd5 || rd_addr1 == 5'd20)) ? 8'h08 : 8'h00);
      r1b <= r1a;
      if (wr_en2) mem2[wr_addr2] <= wr_data2;
      if (rd_en2) r2a <= mem2[rd_addr2];
      r2b <= r2a;
   end
   assign rd_data1 = lat2 ? r1b : r1a;
   assign rd_data2 = r2b;

   function automatic logic [7:0] ref_pat(input int a);
`ifdef BIST_LFSR_PATTERN_EN
      logic [7:0] s = 8'h01;
      for (int i = 0; i < a; i++) s = s[7] ? ((s << 1) ^ 8'h71) : (s << 1);
      return s;
`else
      logic [7:0] v = 8'(a);
      return a[0] ? ~v : v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] ex);
      checks++;
      assert (obs === ex) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, ex);
      end
   endtask

   task automatic run(input bit sel, input bit inj, output int de, output int nd, output logic ba);
      de = -1;
      nd = 0;
      ba = 1'b1;
      if (sel) start2 = 1'b1; else start1 = 1'b1;
      for (int k = 0; k < 150; k++) begin
         @(posedge clk); #1;
         start1 = 1'b0;
         start2 = 1'b0;
         if (k == 0) begin
            check("busy_rise", sel ? busy2 : busy1, 1);
            check("pass_clr", sel ? pass2 : pass1, 0);
            check("err_clr", sel ? err2 : err1, 0);
         end
         if (k < 32) begin
            check("wr_en", sel ? wr_en2 : wr_en1, 1);
            check("wr_addr", sel ? wr_addr2 : wr_addr1, k);
            check("wr_data", sel ? wr_data2 : wr_data1, ref_pat(k));
         end
         if (de >= 0 && k == de + 1) ba = sel ? busy2 : busy1;
         if (sel ? done2 : done1) begin
            nd++;
            if (de < 0) de = k;
         end
         if (inj && (k == 4 || k == 39 || k == de)) begin
            if (sel) start2 = 1'b1; else start1 = 1'b1;
         end
      end
   endtask

   initial begin
      int d;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", {busy1, done1, pass1, wr_en1, rd_en1}, 0);
      check("rst_err", err1, 0);
      check("rst_first", first1, 0);
      check("rst_data", {wr_addr1, wr_data1}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run(0, 0, dedge, ndone, bafter);
      check("clean_done_edge", dedge, 66);
      check("clean_ndone", ndone, 1);
      check("clean_busy_fall", bafter, 0);
      check("clean_pass", pass1, 1);
      check("clean_err", err1, 0);
      check("clean_first", first1, 0);

      flip = 1'b1;
      run(0, 0, dedge, ndone, bafter);
      flip = 1'b0;
      check("fault_done_edge", dedge, 66);
      check("fault_pass", pass1, 0);
      check("fault_err", err1, 2);
      check("fault_first", first1, 5);

      run(0, 0, dedge, ndone, bafter);
      check("reclean_pass", pass1, 1);
      check("reclean_err", err1, 0);
      check("reclean_first", first1, 0);

      run(0, 1, dedge, ndone, bafter);
      check("ign_done_edge", dedge, 66);
      check("ign_ndone", ndone, 1);
      check("ign_busy_fall", bafter, 0);
      check("ign_pass", pass1, 1);

      start1 = 1'b1;
      for (int k = 0; k <= 43; k++) begin
         @(posedge clk); #1;
         start1 = 1'b0;
      end
      check("mid_rd_en", rd_en1, 1);
      check("mid_rd_addr", rd_addr1, 10);
      rst_n = 1'b0;
      #1;
      check("async_ctrl", {busy1, done1, pass1, wr_en1, rd_en1}, 0);
      check("async_cnt", {err1, first1, rd_addr1, wr_data1}, 0);
      d = 0;
      repeat (5) begin
         @(posedge clk); #1;
         d += int'(done1);
      end
      check("async_no_done", d, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run(0, 0, dedge, ndone, bafter);
      check("post_rst_edge", dedge, 66);
      check("post_rst_pass", pass1, 1);

      run(1, 0, dedge, ndone, bafter);
      check("lat2_done_edge", dedge, 67);
      check("lat2_ndone", ndone, 1);
      check("lat2_pass", pass2, 1);
      check("lat2_err", err2, 0);

      lat2 = 1'b1;
      run(0, 0, dedge, ndone, bafter);
      lat2 = 1'b0;
      check("misalign_done_edge", dedge, 66);
      check("misalign_err", err1, 32);
      check("misalign_pass", pass1, 0);
      check("misalign_first", first1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
